// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule generator.
// A start request loads the cipher key into round slot 0. Each following clock
// derives one more round key, until all 11 round keys sit in one packed
// register that stays stable until the next start.
//
// Handshake: start is a single-cycle request that is honoured only in IDLE or
// DONE. It is dropped, not queued, while busy=1. expanded_key is meaningful only
// while key_valid=1. busy and key_valid are never high together.
//
// The FSM state lives in state_q (type state_e), so an external checker can
// bind to it directly.
module aes_key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [127:0]                  key_in,
  output logic                          busy,
  output logic                          key_valid,
  output logic [128*(NUM_ROUNDS+1)-1:0] expanded_key
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  // AES S-box. Entry 0 is at the MSB end, so byte x lives at bit offset (255-x)*8.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // ~x equals 255-x, so {~x, 3'b000} is the bit offset of entry x.
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX_TBL[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         key_valid_q, key_valid_d;
  logic [127:0] slot_q [0:NUM_ROUNDS];
  logic [127:0] slot_d [0:NUM_ROUNDS];

  logic [127:0] prev_key;
  logic [31:0]  w0, w1, w2, w3, t_word;
  logic [31:0]  n0, n1, n2, n3;

  // One key-schedule step from the previous round key and the current rcon.
  always_comb begin
    prev_key = slot_q[rnd_q - 4'd1];
    w0 = prev_key[127:96];
    w1 = prev_key[95:64];
    w2 = prev_key[63:32];
    w3 = prev_key[31:0];
    // RotWord moves byte a0 of w3 to the end; SubWord applies the S-box to each byte.
    t_word = {sbox(w3[23:16]) ^ rcon_q, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = w0 ^ t_word;
    n1 = n0 ^ w1;
    n2 = n1 ^ w2;
    n3 = n2 ^ w3;
  end

  // Next-state logic for the FSM, round counter, rcon and slot register.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    rcon_d      = rcon_q;
    busy_d      = busy_q;
    key_valid_d = key_valid_q;
    for (int i = 0; i <= NUM_ROUNDS; i++) slot_d[i] = slot_q[i];

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          slot_d[0] = key_in;
          for (int i = 1; i <= NUM_ROUNDS; i++) slot_d[i] = '0;
          rnd_d       = 4'd1;
          rcon_d      = 8'h01;
          busy_d      = 1'b1;
          key_valid_d = 1'b0;
          state_d     = EXPAND;
        end
      end
      EXPAND: begin
        slot_d[rnd_q] = {n0, n1, n2, n3};
        rcon_d        = xtime(rcon_q);
        rnd_d         = rnd_q + 4'd1;
        if (rnd_q == 4'(NUM_ROUNDS)) begin
          busy_d      = 1'b0;
          key_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset clears everything and overrides any start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      rcon_q      <= 8'h01;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      rcon_q      <= rcon_d;
      busy_q      <= busy_d;
      key_valid_q <= key_valid_d;
      for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign busy      = busy_q;
  assign key_valid = key_valid_q;

  // Round r occupies bits [1407-128r : 1280-128r], so round 0 is at the top.
  for (genvar g = 0; g <= NUM_ROUNDS; g++) begin : g_pack
    assign expanded_key[(NUM_ROUNDS-g)*128 +: 128] = slot_q[g];
  end

endmodule
